// File: rtl/cgra_seq_pkg.sv
// Shared types, sizes and helpers for the CGRA context sequencer.
package cgra_seq_pkg;

  localparam int CONTEXT_DEPTH = 16;
  localparam int PC_WIDTH      = $clog2(CONTEXT_DEPTH);
  localparam int NUM_STALL_SRC = 4;
  localparam int ITER_WIDTH    = 16;
  localparam int COUNTER_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2,
    ABORT   = 2'd3
  } cause_t;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [COUNTER_W-1:0] sat_inc(input logic [COUNTER_W-1:0] v);
    logic [COUNTER_W-1:0] r;
    if (v == {COUNTER_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(COUNTER_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/cgra_ctx_pc_gen.sv
// Context PC generator: walks the latched slot window and counts completed passes.
module cgra_ctx_pc_gen #(
  parameter int PC_WIDTH   = 4,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic                  advance_i,
  input  logic [PC_WIDTH-1:0]   pc_start_i,
  input  logic [PC_WIDTH-1:0]   pc_end_i,
  input  logic [ITER_WIDTH-1:0] iter_count_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [ITER_WIDTH-1:0] iter_o,
  output logic                  last_pass_done_o
);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   start_q, start_d;
  logic [PC_WIDTH-1:0]   end_q, end_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
  logic                  at_end_s;

  assign at_end_s = (pc_q == end_q);

  // A zero iteration count means unbounded, so it never produces a last pass.
  assign last_pass_done_o = advance_i && at_end_s && (iter_count_q != {ITER_WIDTH{1'b0}})
                            && ((iter_q + ITER_WIDTH'(1)) == iter_count_q);

  always_comb begin
    pc_d         = pc_q;
    start_d      = start_q;
    end_d        = end_q;
    iter_d       = iter_q;
    iter_count_d = iter_count_q;
    if (load_i) begin
      pc_d         = pc_start_i;
      start_d      = pc_start_i;
      end_d        = pc_end_i;
      iter_count_d = iter_count_i;
      iter_d       = {ITER_WIDTH{1'b0}};
    end else if (clr_i) begin
      pc_d = {PC_WIDTH{1'b0}};
    end else if (advance_i) begin
      if (at_end_s) begin
        pc_d   = start_q;
        iter_d = iter_q + ITER_WIDTH'(1);
      end else begin
        pc_d = pc_q + PC_WIDTH'(1);
      end
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= {PC_WIDTH{1'b0}};
      start_q      <= {PC_WIDTH{1'b0}};
      end_q        <= {PC_WIDTH{1'b0}};
      iter_q       <= {ITER_WIDTH{1'b0}};
      iter_count_q <= {ITER_WIDTH{1'b0}};
    end else begin
      pc_q         <= pc_d;
      start_q      <= start_d;
      end_q        <= end_d;
      iter_q       <= iter_d;
      iter_count_q <= iter_count_d;
    end
  end

  assign pc_o   = pc_q;
  assign iter_o = iter_q;

endmodule

// File: rtl/cgra_context_sequencer.sv
// CGRA array conductor: run/pause/finish FSM, masked stall merge, termination cause
// and RUN/stall performance counters around the context PC generator.
module cgra_context_sequencer
  import cgra_seq_pkg::*;
#(
  parameter int CTX_DEPTH  = CONTEXT_DEPTH,
  parameter int PC_W       = $clog2(CTX_DEPTH),
  parameter int STALL_SRCS = NUM_STALL_SRC,
  parameter int ITER_W     = ITER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  soft_reset_i,
  input  logic                  pause_i,
  input  logic                  resume_i,
  input  logic [PC_W-1:0]       pc_start_i,
  input  logic [PC_W-1:0]       pc_end_i,
  input  logic [ITER_W-1:0]     iter_count_i,
  input  logic [31:0]           max_cycles_i,
  input  logic [STALL_SRCS-1:0] stall_src_i,
  input  logic [STALL_SRCS-1:0] stall_mask_i,
  input  logic                  array_done_i,
  output logic                  busy_o,
  output logic                  paused_o,
  output logic                  done_o,
  output logic [1:0]            cause_o,
  output logic                  pe_enable_o,
  output logic                  pe_reset_o,
  output logic [PC_W-1:0]       context_pc_o,
  output logic [ITER_W-1:0]     iter_o,
  output logic [31:0]           cycle_count_o,
  output logic [31:0]           stall_count_o
);

  state_t               state_q, state_d;
  cause_t               cause_q, cause_d;
  logic [COUNTER_W-1:0] max_cycles_q, max_cycles_d;
  logic [COUNTER_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [COUNTER_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                 pe_reset_q, pe_reset_d;
  logic                 stall_s, timeout_s, last_pass_s;
  logic                 pc_load_s, pc_clr_s, pc_adv_s;

  assign stall_s   = |(stall_src_i & stall_mask_i);
  assign timeout_s = (max_cycles_q != 32'd0) && (cycle_cnt_q >= max_cycles_q);
  assign pc_load_s = (state_q == IDLE) && start_i && !soft_reset_i;
  assign pc_clr_s  = (state_q == IDLE) && soft_reset_i;
  assign pc_adv_s  = (state_q == RUN) && !stall_s;

  cgra_ctx_pc_gen #(
    .PC_WIDTH   (PC_W),
    .ITER_WIDTH (ITER_W)
  ) u_pc_gen (
    .clk              (clk),
    .rst              (rst),
    .load_i           (pc_load_s),
    .clr_i            (pc_clr_s),
    .advance_i        (pc_adv_s),
    .pc_start_i       (pc_start_i),
    .pc_end_i         (pc_end_i),
    .iter_count_i     (iter_count_i),
    .pc_o             (context_pc_o),
    .iter_o           (iter_o),
    .last_pass_done_o (last_pass_s)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    max_cycles_d = max_cycles_q;
    cycle_cnt_d  = cycle_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    pe_reset_d   = soft_reset_i;
    case (state_q)
      IDLE: begin
        if (start_i && !soft_reset_i) begin
          state_d      = RUN;
          cause_d      = NONE;
          max_cycles_d = max_cycles_i;
          cycle_cnt_d  = {COUNTER_W{1'b0}};
          stall_cnt_d  = {COUNTER_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The exit cycle is still a RUN cycle, so it is counted like any other.
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        if (stall_s) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
        if (soft_reset_i) begin
          state_d = FINISH;
          cause_d = ABORT;
        end else if (array_done_i || last_pass_s) begin
          state_d = FINISH;
          cause_d = DONE;
        end else if (timeout_s) begin
          state_d = FINISH;
          cause_d = TIMEOUT;
        end else if (pause_i) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (soft_reset_i) begin
          state_d = FINISH;
          cause_d = ABORT;
        end else if (resume_i) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cause_q      <= NONE;
      max_cycles_q <= {COUNTER_W{1'b0}};
      cycle_cnt_q  <= {COUNTER_W{1'b0}};
      stall_cnt_q  <= {COUNTER_W{1'b0}};
      pe_reset_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      max_cycles_q <= max_cycles_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      pe_reset_q   <= pe_reset_d;
    end
  end

  assign busy_o        = (state_q == RUN) || (state_q == PAUSE);
  assign paused_o      = (state_q == PAUSE);
  assign done_o        = (state_q == FINISH);
  assign cause_o       = cause_q;
  assign pe_enable_o   = (state_q == RUN) && !stall_s;
  assign pe_reset_o    = pe_reset_q;
  assign cycle_count_o = cycle_cnt_q;
  assign stall_count_o = stall_cnt_q;

endmodule
